// File: rtl/instruction_decode.sv
// ID stage of the 5-stage MIPS pipeline: register file, control decode,
// branch/jump resolution, load-use stall detection and the ID/EX register.
module instruction_decode #(
  parameter int len      = 32,
  parameter int num_regs = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [len-1:0] in_pc_branch,
  input  logic [len-1:0] in_instruction,
  input  logic           in_wb_write,
  input  logic [4:0]     in_wb_addr,
  input  logic [len-1:0] in_wb_data,
  input  logic           in_ex_mem_read,
  input  logic [4:0]     in_ex_rt,
  output logic [2:0]     out_pc_src,
  output logic [len-1:0] out_pc_jump,
  output logic [len-1:0] out_pc_branch,
  output logic [len-1:0] out_pc_register,
  output logic           out_pc_enable,
  output logic [len-1:0] out_reg1,
  output logic [len-1:0] out_reg2,
  output logic [len-1:0] out_imm,
  output logic [4:0]     out_rs,
  output logic [4:0]     out_rt,
  output logic [4:0]     out_rd,
  output logic [len-1:0] out_link,
  output logic           out_reg_write,
  output logic           out_mem_read,
  output logic           out_mem_write,
  output logic           out_mem_to_reg,
  output logic           out_alu_src,
  output logic           out_is_link,
  output logic [1:0]     out_reg_dst,
  output logic [3:0]     out_alu_op
);

  localparam logic [5:0] op_rtype = 6'h00, op_j    = 6'h02, op_jal  = 6'h03;
  localparam logic [5:0] op_beq   = 6'h04, op_bne  = 6'h05, op_addi = 6'h08;
  localparam logic [5:0] op_slti  = 6'h0A, op_andi = 6'h0C, op_ori  = 6'h0D;
  localparam logic [5:0] op_xori  = 6'h0E, op_lui  = 6'h0F, op_lw   = 6'h23;
  localparam logic [5:0] op_sw    = 6'h2B, fn_jr   = 6'h08, fn_jalr = 6'h09;

  localparam logic [3:0] alu_rtype = 4'h0, alu_add = 4'h1, alu_slt = 4'h2, alu_and = 4'h3;
  localparam logic [3:0] alu_or    = 4'h4, alu_xor = 4'h5, alu_lui = 4'h6, alu_sub = 4'h7;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = in_instruction[31:26];
  assign rs     = in_instruction[25:21];
  assign rt     = in_instruction[20:16];
  assign rd     = in_instruction[15:11];
  assign imm16  = in_instruction[15:0];
  assign funct  = in_instruction[5:0];

  logic [len-1:0] regs [num_regs];
  logic [len-1:0] rs_val, rt_val, imm_sext, imm_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < num_regs; i++) regs[i] <= '0;
    end else if (in_wb_write && in_wb_addr != 5'd0) begin
      regs[in_wb_addr] <= in_wb_data;
    end
  end

  // Write-through read so WB and ID can share a cycle without a hazard.
  function automatic logic [len-1:0] rf_read(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
    if (in_wb_write && in_wb_addr == addr) return in_wb_data;
    return regs[addr];
  endfunction

  assign rs_val = rf_read(rs);
  assign rt_val = rf_read(rt);

  logic       flush_q, stall, taken, bubble;
  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic       dec_alu_src, dec_is_link, use_rt, zero_ext;
  logic       is_beq, is_bne, is_jump, is_jump_reg;
  logic [1:0] dec_reg_dst;
  logic [3:0] dec_alu_op;

  // A wrong-path word (flush_q) decodes to all-zero control and flags.
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_is_link    = 1'b0;
    dec_reg_dst    = 2'b00;
    dec_alu_op     = alu_rtype;
    use_rt         = 1'b0;
    zero_ext       = 1'b0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_jump        = 1'b0;
    is_jump_reg    = 1'b0;
    if (!flush_q) begin
      case (opcode)
        op_rtype: begin
          if (funct == fn_jr) begin
            is_jump_reg = 1'b1;
          end else if (funct == fn_jalr) begin
            is_jump_reg   = 1'b1;
            dec_reg_write = 1'b1;
            dec_reg_dst   = 2'b01;
            dec_is_link   = 1'b1;
          end else begin
            dec_reg_write = 1'b1;
            dec_reg_dst   = 2'b01;
            use_rt        = 1'b1;
          end
        end
        op_j:   is_jump = 1'b1;
        op_jal: begin
          is_jump       = 1'b1;
          dec_reg_write = 1'b1;
          dec_reg_dst   = 2'b10;
          dec_is_link   = 1'b1;
        end
        op_beq: begin is_beq = 1'b1; use_rt = 1'b1; dec_alu_op = alu_sub; end
        op_bne: begin is_bne = 1'b1; use_rt = 1'b1; dec_alu_op = alu_sub; end
        op_addi, op_slti, op_andi, op_ori, op_xori, op_lui: begin
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          case (opcode)
            op_addi: dec_alu_op = alu_add;
            op_slti: dec_alu_op = alu_slt;
            op_andi: begin dec_alu_op = alu_and; zero_ext = 1'b1; end
            op_ori:  begin dec_alu_op = alu_or;  zero_ext = 1'b1; end
            op_xori: begin dec_alu_op = alu_xor; zero_ext = 1'b1; end
            default: dec_alu_op = alu_lui;
          endcase
        end
        op_lw: begin
          dec_reg_write  = 1'b1;
          dec_mem_read   = 1'b1;
          dec_mem_to_reg = 1'b1;
          dec_alu_src    = 1'b1;
          dec_alu_op     = alu_add;
        end
        op_sw: begin
          dec_mem_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_alu_op    = alu_add;
          use_rt        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall  = !flush_q && in_ex_mem_read && (in_ex_rt != 5'd0) &&
                  ((in_ex_rt == rs) || ((in_ex_rt == rt) && use_rt));
  assign taken  = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
  assign bubble = stall || flush_q;

  always_comb begin
    out_pc_src = 3'b000;
    if (!stall) begin
      if (taken)            out_pc_src = 3'b001;
      else if (is_jump)     out_pc_src = 3'b010;
      else if (is_jump_reg) out_pc_src = 3'b100;
    end
  end

  assign imm_sext        = {{(len-16){imm16[15]}}, imm16};
  assign imm_ext         = zero_ext ? {{(len-16){1'b0}}, imm16} : imm_sext;
  assign out_pc_branch   = in_pc_branch + (imm_sext << 2);
  assign out_pc_jump     = {in_pc_branch[len-1:len-4], in_instruction[25:0], 2'b00};
  assign out_pc_register = rs_val;
  assign out_pc_enable   = reset || !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q        <= 1'b0;
      out_reg1       <= '0;
      out_reg2       <= '0;
      out_imm        <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
      out_link       <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_alu_src    <= 1'b0;
      out_is_link    <= 1'b0;
      out_reg_dst    <= 2'b00;
      out_alu_op     <= 4'h0;
    end else begin
      flush_q        <= (out_pc_src != 3'b000);
      out_reg1       <= rs_val;
      out_reg2       <= rt_val;
      out_imm        <= imm_ext;
      out_rs         <= rs;
      out_rt         <= rt;
      out_rd         <= rd;
      out_link       <= in_pc_branch;
      out_reg_write  <= dec_reg_write  && !bubble;
      out_mem_read   <= dec_mem_read   && !bubble;
      out_mem_write  <= dec_mem_write  && !bubble;
      out_mem_to_reg <= dec_mem_to_reg && !bubble;
      out_alu_src    <= dec_alu_src    && !bubble;
      out_is_link    <= dec_is_link    && !bubble;
      out_reg_dst    <= bubble ? 2'b00 : dec_reg_dst;
      out_alu_op     <= bubble ? 4'h0  : dec_alu_op;
    end
  end

endmodule
